// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, RV32M funct3 encodings and
// the multiply/divide FSM state type.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, with sign fixup and special-case overrides.
module muldiv_core
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Divide reuses acc as {remainder, quotient} and mcand[XLEN-1:0] as divisor.
    logic [W2-1:0]   acc;
    logic [W2-1:0]   mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] a_raw;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;
    logic            div_ovf;

    logic            is_div;
    logic            sign_a;
    logic            sign_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    always_comb begin
        is_div    = op[2];
        sign_a    = is_div ? ~op[0] : (op[1:0] != 2'b11);
        sign_b    = is_div ? ~op[0] : ~op[1];
        neg_a     = sign_a & a[XLEN-1];
        neg_b     = sign_b & b[XLEN-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;
        div_shift = {acc[W2-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand[XLEN-1:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            a_raw    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (load) begin
            acc      <= is_div ? {{XLEN{1'b0}}, mag_a} : '0;
            mcand    <= {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
            mplier   <= mag_b;
            a_raw    <= a;
            neg_res  <= neg_a ^ neg_b;
            neg_rem  <= neg_a;
            div_zero <= is_div && (b == '0);
            div_ovf  <= is_div && !op[0] && (a == MIN_NEG) && (b == '1);
        end else if (step) begin
            if (op[2]) begin
                if (!div_diff[XLEN])
                    acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                else
                    acc <= {acc[W2-2:0], 1'b0};
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= {mcand[W2-2:0], 1'b0};
                mplier <= {1'b0, mplier[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
        if (!op[2])
            result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        else if (div_zero)
            result = op[1] ? a_raw : '1;
        else if (div_ovf)
            result = op[1] ? '0 : MIN_NEG;
        else
            result = op[1] ? rem : quo;
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: sequences the iterative core, holds the pipeline stall
// while it runs and presents the result with a one-cycle done pulse.
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall_o,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    import pipeline_pkg::*;

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    muldiv_state_t   state;
    logic [CW-1:0]   count;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;
    logic [XLEN-1:0] core_result;
    logic [2:0]      core_op;
    logic            accept;
    logic            step;

    always_comb begin
        accept  = (state == ST_IDLE) && start && !flush;
        step    = (state == ST_BUSY) && !flush;
        stall_o = (((state == ST_IDLE) && start) || (state == ST_BUSY)) && !flush;
        done    = (state == ST_DONE) && !flush;
        core_op = (state == ST_IDLE) ? funct3 : funct3_q;
        result  = done ? core_result : result_q;
        rd_out  = done ? rd_q : rd_out_q;
    end

    // The held copies only refresh on a completed operation, so the outputs
    // stay stable across idle cycles and aborted operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_BUSY;
                        count    <= '0;
                        funct3_q <= funct3;
                        rd_q     <= rd_in;
                    end
                end
                ST_BUSY: begin
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    result_q <= core_result;
                    rd_out_q <= rd_q;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    muldiv_core u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (step),
        .op     (core_op),
        .a      (op_a),
        .b      (op_b),
        .result (core_result)
    );

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed M-extension vectors, latency and
// stall checks, flush abort and asynchronous reset mid-operation.
module tb_ex_muldiv;
    import pipeline_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        stall_o;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flush   (flush),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_in   (rd_in),
        .stall_o (stall_o),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 with result 0x%08h, expected no done", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            end
        end
    end

    // Issues one operation in cycle 0 and holds it in EX until done, checking
    // stall length and done cycle. Leaves start high so the next call starts
    // back-to-back in the IDLE cycle after DONE.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] exp_res);
        int cyc;
        int stalls;
        bit seen;
        exp_t e;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        e.res  = exp_res;
        e.rd   = rd;
        sb_q.push_back(e);
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("done_cycle", 32'(cyc), 32'd33);
        checkOutput("stall_cycles", 32'(stalls), 32'd33);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bit seen;
        exp_t e;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("reset_stall_idle", {31'd0, stall_o}, 32'd0);
        start = 1'b1;
        #1;
        checkOutput("reset_stall_follows_start", {31'd0, stall_o}, 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(MUL_F3,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        applyStimulus(MULHU_F3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE);
        applyStimulus(MULH_F3,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000);
        applyStimulus(MULHSU_F3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
        applyStimulus(MUL_F3,    32'h0001_2345,  32'h0000_0100, 5'd31, 32'h0123_4500);
        applyStimulus(DIV_F3,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD);
        applyStimulus(REM_F3,    32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF);
        applyStimulus(DIVU_F3,   32'd100,        32'd7,         5'd9,  32'd14);
        applyStimulus(REMU_F3,   32'd100,        32'd7,         5'd10, 32'd2);
        applyStimulus(DIV_F3,    32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF);
        applyStimulus(REMU_F3,   32'd5,          32'd0,         5'd12, 32'd5);
        applyStimulus(DIV_F3,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        applyStimulus(REM_F3,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;

        // Flush a DIVU in cycle 10, then a MUL accepted in cycle 11.
        start  = 1'b1;
        funct3 = DIVU_F3;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        rd_in  = 5'd15;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush  = 1'b0;
        funct3 = MUL_F3;
        op_a   = 32'd3;
        op_b   = 32'd4;
        rd_in  = 5'd9;
        e.res  = 32'd12;
        e.rd   = 5'd9;
        sb_q.push_back(e);
        cyc  = 11;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("flush_next_done_cycle", 32'(cyc), 32'd44);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in cycle 20 of a MUL.
        start  = 1'b1;
        funct3 = MUL_F3;
        op_a   = 32'h0000_1234;
        op_b   = 32'h0000_5678;
        rd_in  = 5'd21;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        checkOutput("midreset_rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("midreset_stall", {31'd0, stall_o}, 32'd1);
        start = 1'b0;
        #1;
        checkOutput("midreset_stall_idle", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipeline. It reads the operands and destination register leaving the ID/EX register and computes one M-extension result. While it computes, it holds a stall request that freezes PC, IF/ID and ID/EX. When the result is ready it releases the stall so the instruction advances to EX/MEM with its result.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- ITER, 32, number of iteration cycles; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  EX holds a valid M-extension instruction (the instruction decoded `opcode=0110011` with `funct7=0000001`).
- flush  in  1  kill the EX instruction; aborts any operation in progress.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value after forwarding.
- op_b  in  XLEN  rs2 value after forwarding.
- rd_in  in  5  destination register from ID/EX.
- stall_o  out  1  freeze request to the hazard unit.
- done  out  1  one-cycle pulse: result and rd_out are valid.
- result  out  XLEN  operation result.
- rd_out  out  5  destination register of the completed operation.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and flush=0: capture funct3, op_a, op_b and rd_in; load the datapath; set count=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one iteration per cycle; count increments each cycle.
  - When count=ITER-1, the last iteration completes and the FSM goes to DONE.
- DONE: done=1 with result and rd_out valid; go to IDLE next cycle.
  - start is ignored in DONE because the same instruction is still in EX.
- flush=1 in any state: go to IDLE next cycle, with no done pulse for the aborted operation.
- stall_o = ((IDLE and start) or BUSY) and not flush. stall_o is combinational and is 0 in DONE.
- Multiply: shift-add on operand magnitudes giving a 64-bit product, then a sign fixup.
  - MUL and MULH treat both operands as signed.
  - MULHSU treats op_a as signed and op_b as unsigned.
  - MULHU treats both as unsigned.
  - MUL returns the low 32 bits; the MULH variants return the high 32 bits.
- Divide: restoring division on magnitudes.
  - Signed ops negate the quotient when the operand signs differ.
  - Signed ops give the remainder the sign of the dividend.
- Special cases are detected at capture but still take the full latency:
  - op_b=0: quotient 0xFFFFFFFF, remainder = op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- result and rd_out hold their values after DONE until the next DONE.
- Reset sets state IDLE and clears every register. Outputs after reset: stall_o follows start, done=0, result=0, rd_out=0.

## Timing
- Let cycle 0 be the first cycle in which start=1 is seen in IDLE.
- stall_o is high in cycles 0..32, for 33 stall cycles.
- DONE occurs in cycle 33: done=1 and stall_o=0, so EX/MEM captures result on the rising edge that ends cycle 33.
- Latency is fixed for every funct3 and every operand value.
- Back-to-back M instructions: the FSM is in IDLE at cycle 34, and the next start is accepted in that cycle. Throughput is one operation per 34 cycles.
- Flush in cycle k:
  - stall_o=0 in cycle k.
  - State is IDLE at cycle k+1.
  - A new start is accepted at cycle k+1.
- Reset mid-operation: all registers clear immediately (asynchronous); there is no done pulse and no partial result.

## Structure
- Shared package pipeline_pkg holds:
  - XLEN.
  - The funct3 encodings MUL_F3..REMU_F3.
  - The FSM state enum muldiv_state_t.
- One sub-module, muldiv_core, holds the iterative datapath: accumulator, shift registers, sign flags and fixup.
  - Its controls are load, step and op.
- ex_muldiv holds the FSM, counter, capture registers and stall logic.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD (-3): stall_o high for exactly 33 cycles; done in cycle 33; result 0xFFFFFFEB; rd_out = captured rd_in.
- High-half multiplies, both operands 0xFFFFFFFF:
  - MULHU gives 0xFFFFFFFE.
  - MULH gives 0x00000000.
  - MULHSU gives 0xFFFFFFFF.
- Division:
  - DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Special cases:
  - DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
  - All of these take 33 stall cycles.
- Flush: assert flush in cycle 10 of a DIVU.
  - stall_o=0 in cycle 10; done never pulses.
  - A new MUL 3*4 started in cycle 11 gives 12 at cycle 44.
- Reset asserted in cycle 20 of a MUL: state IDLE and done=0 in the same cycle; result=0, rd_out=0.
